// File: rtl/hub75_rx.sv
// HUB75 panel-side receiver: resynchronises the panel pins, rebuilds each latched
// row pair and replays it as a pixel write stream, with sticky protocol-error flags.
module hub75_rx #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 5
) (
  input  logic                      clk30,
  input  logic                      reset,
  input  logic [2:0]                hub_rgb0,
  input  logic [2:0]                hub_rgb1,
  input  logic [ADDR_BITS-1:0]      hub_addr,
  input  logic                      hub_blank,
  input  logic                      hub_latch,
  input  logic                      hub_sclk,
  input  logic                      err_clr,
  output logic                      wr_en,
  output logic [$clog2(WIDTH)-1:0]  wr_x,
  output logic [ADDR_BITS:0]        wr_y,
  output logic [2:0]                wr_rgb,
  output logic                      frame_done,
  output logic                      err_count,
  output logic                      err_overrun,
  output logic                      err_unblanked
);
  localparam int XW = $clog2(WIDTH);
  localparam int CW = XW + 1;
  localparam int PW = ADDR_BITS + 9;
  localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

  typedef enum logic {S_IDLE, S_DUMP} state_t;

  logic [PW-1:0]        r_s1, r_s2;
  logic [1:0]           r_s3;
  logic [1:0]           r_mask;
  logic [CW-1:0]        r_cnt, r_idx;
  logic [2:0]           r_sh0 [WIDTH];
  logic [2:0]           r_sh1 [WIDTH];
  logic [2:0]           r_hold0 [WIDTH];
  logic [2:0]           r_hold1 [WIDTH];
  logic [ADDR_BITS-1:0] r_addr;
  state_t               r_state;
  logic                 r_wr_en, r_frame_done;
  logic [XW-1:0]        r_wr_x;
  logic [ADDR_BITS:0]   r_wr_y;
  logic [2:0]           r_wr_rgb;
  logic                 r_err_count, r_err_overrun, r_err_unblanked;

  logic [PW-1:0]        w_pins;
  logic [2:0]           w_rgb0, w_rgb1;
  logic [ADDR_BITS-1:0] w_addr;
  logic                 w_blank, w_sclk_rise, w_latch_rise;
  logic [CW-1:0]        w_cnt_nxt;
  logic [2:0]           w_sh0_nxt [WIDTH];
  logic [2:0]           w_sh1_nxt [WIDTH];
  logic                 w_lower;
  logic [XW-1:0]        w_col, w_pos;
  logic [2:0]           w_dump_rgb;

  // Stage p0/p1: two-flop synchroniser; stage p2 exists only for edge detection
  assign w_pins  = {hub_rgb0, hub_rgb1, hub_addr, hub_blank, hub_latch, hub_sclk};
  assign w_rgb0  = r_s2[PW-1 -: 3];
  assign w_rgb1  = r_s2[PW-4 -: 3];
  assign w_addr  = r_s2[3 +: ADDR_BITS];
  assign w_blank = r_s2[2];
  // The mask hides the rise a pin that was already high would fake after reset
  assign w_sclk_rise  = r_s2[0] & ~r_s3[0] & (r_mask == 2'd0);
  assign w_latch_rise = r_s2[1] & ~r_s3[1] & (r_mask == 2'd0);

  assign w_cnt_nxt = (w_sclk_rise && r_cnt != LAST) ? r_cnt + CW'(1) : r_cnt;

  // Shift happens before a coincident latch copy, so the copy sees the new pixel
  always_comb begin
    w_sh0_nxt = r_sh0;
    w_sh1_nxt = r_sh1;
    if (w_sclk_rise) begin
      w_sh0_nxt[0] = w_rgb0;
      w_sh1_nxt[0] = w_rgb1;
      for (int i = 1; i < WIDTH; i++) begin
        w_sh0_nxt[i] = r_sh0[i-1];
        w_sh1_nxt[i] = r_sh1[i-1];
      end
    end
  end

  // Column 0 is the deepest entry, so column c lives at WIDTH-1-c
  assign w_lower    = (r_idx < CW'(WIDTH));
  assign w_col      = w_lower ? r_idx[XW-1:0] : XW'(r_idx - CW'(WIDTH));
  assign w_pos      = XW'(WIDTH - 1) - w_col;
  assign w_dump_rgb = w_lower ? r_hold0[w_pos] : r_hold1[w_pos];

  always_ff @(posedge clk30) begin
    if (reset) begin
      r_s1            <= '0;
      r_s2            <= '0;
      r_s3            <= '0;
      r_mask          <= 2'd3;
      r_cnt           <= '0;
      r_idx           <= '0;
      r_sh0           <= '{default: '0};
      r_sh1           <= '{default: '0};
      r_hold0         <= '{default: '0};
      r_hold1         <= '{default: '0};
      r_addr          <= '0;
      r_state         <= S_IDLE;
      r_wr_en         <= 1'b0;
      r_wr_x          <= '0;
      r_wr_y          <= '0;
      r_wr_rgb        <= '0;
      r_frame_done    <= 1'b0;
      r_err_count     <= 1'b0;
      r_err_overrun   <= 1'b0;
      r_err_unblanked <= 1'b0;
    end else begin
      r_s1 <= w_pins;
      r_s2 <= r_s1;
      r_s3 <= r_s2[1:0];
      if (r_mask != 2'd0) r_mask <= r_mask - 2'd1;

      r_sh0 <= w_sh0_nxt;
      r_sh1 <= w_sh1_nxt;
      r_cnt <= w_latch_rise ? '0 : w_cnt_nxt;

      // A set event outranks a simultaneous clear
      r_err_count     <= (r_err_count & ~err_clr) | (w_latch_rise && w_cnt_nxt != CW'(WIDTH));
      r_err_unblanked <= (r_err_unblanked & ~err_clr) | (w_latch_rise && !w_blank);
      r_err_overrun   <= (r_err_overrun & ~err_clr) | (w_latch_rise && r_state == S_DUMP);

      case (r_state)
        S_IDLE: begin
          r_wr_en      <= 1'b0;
          r_frame_done <= 1'b0;
          if (w_latch_rise) begin
            r_hold0  <= w_sh0_nxt;
            r_hold1  <= w_sh1_nxt;
            r_addr   <= w_addr;
            r_state  <= S_DUMP;
            r_idx    <= CW'(1);
            // Write 0 goes out immediately so the stream starts right after detect
            r_wr_en  <= 1'b1;
            r_wr_x   <= '0;
            r_wr_y   <= {1'b0, w_addr};
            r_wr_rgb <= w_sh0_nxt[WIDTH-1];
          end
        end
        S_DUMP: begin
          r_wr_en      <= 1'b1;
          r_wr_x       <= w_col;
          r_wr_y       <= {~w_lower, r_addr};
          r_wr_rgb     <= w_dump_rgb;
          r_frame_done <= (r_idx == LAST) && (&r_addr);
          r_idx        <= r_idx + CW'(1);
          if (r_idx == LAST) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_en         = r_wr_en;
  assign wr_x          = r_wr_x;
  assign wr_y          = r_wr_y;
  assign wr_rgb        = r_wr_rgb;
  assign frame_done    = r_frame_done;
  assign err_count     = r_err_count;
  assign err_overrun   = r_err_overrun;
  assign err_unblanked = r_err_unblanked;
endmodule

// File: tb/tb_hub75_rx.sv
// Bench for hub75_rx: drives HUB75 pin sequences and compares the write stream and
// error flags with a history-based model of what the panel should have received.
module tb_hub75_rx;
  localparam int W  = 64;
  localparam int AB = 5;

  logic          clk30 = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    hub_rgb0 = '0, hub_rgb1 = '0;
  logic [AB-1:0] hub_addr = '0;
  logic          hub_blank = 1'b1, hub_latch = 1'b0, hub_sclk = 1'b0, err_clr = 1'b0;
  logic          wr_en, frame_done, err_count, err_overrun, err_unblanked;
  logic [5:0]    wr_x;
  logic [AB:0]   wr_y;
  logic [2:0]    wr_rgb;

  hub75_rx #(.WIDTH(W), .ADDR_BITS(AB)) dut (
    .clk30(clk30), .reset(reset),
    .hub_rgb0(hub_rgb0), .hub_rgb1(hub_rgb1), .hub_addr(hub_addr),
    .hub_blank(hub_blank), .hub_latch(hub_latch), .hub_sclk(hub_sclk),
    .err_clr(err_clr), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
    .frame_done(frame_done), .err_count(err_count), .err_overrun(err_overrun),
    .err_unblanked(err_unblanked)
  );

  always #16 clk30 = ~clk30;

  int cyc = 0;
  always @(posedge clk30) cyc <= cyc + 1;

  // Observed writes: {frame_done, y, x, rgb} plus the cycle each appeared in
  logic [15:0] mon_q [$];
  int          mon_cyc [$];
  always @(negedge clk30) begin
    if (wr_en) begin
      mon_q.push_back({frame_done, wr_y, wr_x, wr_rgb});
      mon_cyc.push_back(cyc);
    end
  end

  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: every pixel ever shifted; a latch takes the newest W of them
  logic [2:0]  h0 [$];
  logic [2:0]  h1 [$];
  logic [15:0] exp_q [$];
  int          m_cnt, m_accept, m_first, fd_seen;
  bit          m_ec, m_eo, m_eu;

  task automatic model_reset();
    h0.delete(); h1.delete(); exp_q.delete();
    for (int i = 0; i < W; i++) begin
      h0.push_back(3'd0);
      h1.push_back(3'd0);
    end
    m_cnt = 0; m_accept = -100000; m_first = 0;
    m_ec = 0; m_eo = 0; m_eu = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk30);
      #2;
    end
  endtask

  // Called when the latch pin is driven high; the receiver acts 3 edges later
  task automatic model_latch();
    int act, n;
    logic fd;
    act = cyc + 3;
    if (m_cnt != W) m_ec = 1;
    if (!hub_blank) m_eu = 1;
    if (act > m_accept && act < m_accept + 2 * W) begin
      m_eo = 1;
    end else begin
      m_accept = act;
      m_first  = act;
      n = h0.size();
      for (int c = 0; c < W; c++)
        exp_q.push_back({1'b0, 1'b0, hub_addr, 6'(c), h0[n - W + c]});
      for (int c = 0; c < W; c++) begin
        fd = (c == W - 1) && (hub_addr == {AB{1'b1}});
        exp_q.push_back({fd, 1'b1, hub_addr, 6'(c), h1[n - W + c]});
      end
    end
    m_cnt = 0;
  endtask

  task automatic send_col(input logic [2:0] r0, input logic [2:0] r1);
    hub_rgb0 = r0;
    hub_rgb1 = r1;
    step(2);
    hub_sclk = 1'b1;
    h0.push_back(r0);
    h1.push_back(r1);
    m_cnt++;
    step(2);
    hub_sclk = 1'b0;
    step(1);
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send_col(3'($urandom), 3'($urandom));
  endtask

  task automatic do_latch();
    hub_latch = 1'b1;
    model_latch();
    step(2);
    hub_latch = 1'b0;
    step(2);
  endtask

  task automatic coincident(input logic [2:0] r0, input logic [2:0] r1);
    hub_rgb0 = r0;
    hub_rgb1 = r1;
    step(2);
    hub_sclk  = 1'b1;
    hub_latch = 1'b1;
    h0.push_back(r0);
    h1.push_back(r1);
    m_cnt++;
    model_latch();
    step(2);
    hub_sclk  = 1'b0;
    hub_latch = 1'b0;
    step(2);
  endtask

  task automatic do_clr();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    m_ec = 0; m_eo = 0; m_eu = 0;
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_err_count"}, 32'(err_count), 32'(m_ec));
    check({tag, "_err_overrun"}, 32'(err_overrun), 32'(m_eo));
    check({tag, "_err_unblanked"}, 32'(err_unblanked), 32'(m_eu));
  endtask

  task automatic wait_dump(input string tag);
    int budget, gaps, n;
    budget = 0;
    while (mon_q.size() < exp_q.size() && budget < 600) begin
      step(1);
      budget++;
    end
    step(4);
    check({tag, "_nwrites"}, 32'(mon_q.size()), 32'(exp_q.size()));
    if (exp_q.size() > 0 && mon_q.size() > 0) begin
      check({tag, "_latency"}, 32'(mon_cyc[0]), 32'(m_first));
      gaps = 0;
      for (int i = 0; i < mon_cyc.size(); i++)
        if (mon_cyc[i] != mon_cyc[0] + i) gaps++;
      check({tag, "_gaps"}, 32'(gaps), 32'd0);
    end
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_wr%0d", tag, i), 32'(mon_q[i]), 32'(exp_q[i]));
    foreach (mon_q[i]) if (mon_q[i][15]) fd_seen++;
    mon_q.delete(); mon_cyc.delete(); exp_q.delete();
  endtask

  initial begin
    int budget;
    model_reset();
    step(3);
    reset = 1'b0;
    step(4);
    check("reset_wr_en", 32'(wr_en), 32'd0);
    check("reset_wr_x", 32'(wr_x), 32'd0);
    check("reset_wr_y", 32'(wr_y), 32'd0);
    check("reset_wr_rgb", 32'(wr_rgb), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check_errs("reset");

    // Deterministic row: rgb0 = column, rgb1 = ~column, addr 5
    hub_addr = 5'd5;
    for (int x = 0; x < W; x++) send_col(3'(x), ~3'(x));
    do_latch();
    wait_dump("row5");
    check_errs("row5");

    // Full frame with random pixels; exactly one frame_done
    fd_seen = 0;
    for (int a = 0; a < 32; a++) begin
      hub_addr = 5'(a);
      send_rand(W);
      do_latch();
      wait_dump($sformatf("frame%0d", a));
    end
    check("frame_done_pulses", 32'(fd_seen), 32'd1);
    check_errs("frame");

    // Short and long rows
    hub_addr = 5'($urandom);
    send_rand(W - 1);
    do_latch();
    wait_dump("short");
    check_errs("short");
    do_clr();
    check_errs("clr");
    hub_addr = 5'($urandom);
    send_rand(W + 1);
    do_latch();
    wait_dump("long");
    check_errs("long");
    do_clr();

    // Second latch mid-dump is dropped
    hub_addr = 5'($urandom);
    send_rand(W);
    do_latch();
    step(36);
    hub_addr = ~hub_addr;
    do_latch();
    wait_dump("overrun");
    check_errs("overrun");
    do_clr();

    // Latch while the display is not blanked
    hub_blank = 1'b0;
    hub_addr = 5'($urandom);
    send_rand(W);
    do_latch();
    wait_dump("unblank");
    check_errs("unblank");
    hub_blank = 1'b1;
    step(4);
    do_clr();

    // Last sclk rise coincides with the latch rise
    hub_addr = 5'($urandom);
    send_rand(W - 1);
    coincident(3'($urandom), 3'($urandom));
    wait_dump("coincident");
    check_errs("coincident");

    // Reset in the middle of a dump, latch held high across it
    hub_addr = 5'($urandom);
    send_rand(W);
    do_latch();
    budget = 0;
    while (mon_q.size() < 50 && budget < 300) begin
      step(1);
      budget++;
    end
    check("rst_reached_write50", 32'(mon_q.size() >= 50), 32'd1);
    reset = 1'b1;
    hub_latch = 1'b1;
    step(1);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_x", 32'(wr_x), 32'd0);
    check("rst_wr_y", 32'(wr_y), 32'd0);
    check("rst_wr_rgb", 32'(wr_rgb), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    mon_q.delete(); mon_cyc.delete();
    step(2);
    reset = 1'b0;
    step(20);
    check("rst_no_dump", 32'(mon_q.size()), 32'd0);
    hub_latch = 1'b0;
    step(3);
    model_reset();
    check_errs("rst");
    mon_q.delete(); mon_cyc.delete();

    // Normal operation resumes after reset
    hub_addr = 5'($urandom);
    send_rand(W);
    do_latch();
    wait_dump("post_rst");
    check_errs("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
- HUB75 panel-side receiver: the counterpart of our panel driver, standing in for the LED panel.
- Samples the panel pins (rgb0, rgb1, addr, blank, latch, sclk) and reassembles each shifted row pair.
- Emits the received pixels as a write stream into a frame-capture memory, and flags protocol violations.
- Used for on-board loopback and for self-checking benches of the driver.

Parameters:
- WIDTH, 64, columns shifted per row; column counter width is clog2(WIDTH)+1.
- ADDR_BITS, 5, row-address width; the panel has 2^(ADDR_BITS+1) rows.

Ports:
- clk30  input  1  system clock, 30 MHz.
- reset  input  1  synchronous, active-high.
- hub_rgb0  input  3  {R,G,B} for the upper half (row = {0,addr}); async.
- hub_rgb1  input  3  {R,G,B} for the lower half (row = {1,addr}); async.
- hub_addr  input  ADDR_BITS  row address; async.
- hub_blank  input  1  high = display blanked; async.
- hub_latch  input  1  rising edge transfers the shift register to the display row; async.
- hub_sclk  input  1  rising edge shifts one column; async.
- err_clr  input  1  clears all sticky error flags.
- wr_en  output  1  pixel write strobe.
- wr_x  output  clog2(WIDTH)  pixel column.
- wr_y  output  ADDR_BITS+1  pixel row.
- wr_rgb  output  3  pixel {R,G,B}.
- frame_done  output  1  one-cycle pulse, last write of row 2^ADDR_BITS-1 pair.
- err_count  output  1  sticky: latch seen with column count != WIDTH.
- err_overrun  output  1  sticky: latch seen while dumping.
- err_unblanked  output  1  sticky: latch rose while blank was low.

Behaviour:
- Synchronisation:
  - All hub_* inputs pass through 2 flops, then a third stage for edge detection.
  - A pin change is acted on at the 3rd clk30 edge after it.
  - Data, addr and blank are delayed identically to sclk and latch.
  - Sender requirements: sclk high ≥2 cycles and low ≥2 cycles; data stable ≥2 cycles before and after each sclk rise.
- Shift: on each detected sclk rise, shift {rgb0,rgb1} into two WIDTH-deep registers.
  - The first pixel shifted after a latch is column 0.
  - After WIDTH shifts, column 0 sits in the deepest position.
  - The column counter increments and saturates at 2*WIDTH-1.
- Latch, on a detected latch rise:
  - Check column counter != WIDTH → set err_count.
  - Check synced blank == 0 → set err_unblanked.
  - If the FSM is in IDLE: copy both shift registers into hold registers, capture addr, go to DUMP. The copy always happens, even on error.
  - If the FSM is in DUMP: the latch is dropped, hold registers and addr are unchanged, set err_overrun.
  - In both cases the column counter is cleared.
- Simultaneous sclk rise and latch rise in one cycle: the shift occurs first and the copied data includes the new pixel. The counter is checked including that shift, then cleared.
- FSM states:
  - IDLE: wr_en=0.
  - DUMP: idx runs 0..2*WIDTH-1, one write per cycle.
    - idx<WIDTH: wr_y={0,addr}, wr_x=idx, wr_rgb=hold0[column idx].
    - idx≥WIDTH: wr_y={1,addr}, wr_x=idx-WIDTH, wr_rgb=hold1.
    - At idx=2*WIDTH-1, go to IDLE.
- Output registration and timing:
  - All outputs are registered.
  - The first wr_en is asserted on the cycle after the latch-rise detect cycle.
  - There are exactly 2*WIDTH consecutive wr_en cycles with no gaps.
- frame_done: asserted with the final write (idx=2*WIDTH-1) when the captured addr is all ones.
- Shifting continues during DUMP; the shift registers and hold registers are independent.
- Sticky errors:
  - err_clr clears the flags on the next edge.
  - A set event in the same cycle as err_clr wins, and the flag remains 1.
- Reset values:
  - Outputs: wr_en=0, wr_x=0, wr_y=0, wr_rgb=0, frame_done=0, all err_*=0.
  - Internal state: FSM=IDLE, column counter=0, shift/hold registers=0, synchroniser stages=0.
  - Reset mid-DUMP aborts the dump; wr_en=0 from the next edge.
  - After reset the edge detectors must not fire spuriously on a pin that is already high. The synchronisers are loaded with the current value for 2 cycles post-reset, or the detector is masked for 3 cycles.

Test Plan:
- Row transfer: blank=1, addr=5, shift 64 columns with rgb0=x[2:0] and rgb1=~x[2:0], then latch → 128 writes. wr_y=5 with wr_x=0..63 and wr_rgb=x[2:0]; then wr_y=37 with wr_rgb=~x[2:0]. No err flags set.
- Frame: send addr 0..31, each with 64 columns → frame_done is pulsed exactly once, on the final write of addr 31 (wr_y=63, wr_x=63).
- Count error: shift 63 columns then latch → err_count=1, 128 writes still issued. Then err_clr → err_count=0. Next latch with 65 columns → err_count=1.
- Overrun: latch, then a second latch 40 cycles later → err_overrun=1. Dump completes with the first row's data and addr; no second dump occurs.
- Unblanked and coincident edges: latch rise with blank=0 → err_unblanked=1. sclk and latch rising in the same cycle after 63 prior shifts → count OK (64) and column 63 holds the coincident pixel.
- Reset mid-dump: assert reset at write 50 → wr_en=0 on the next cycle and all outputs are 0. With latch held high through reset, no dump occurs after reset.
